seq_merger_n: RTL and testbench
===============================

// Module: seq_merger_n
// PURPOSE
//  N-channel sorted-stream merger: NCH input streams, each ascending (unsigned)
//  and framed by a last flag, merge into one ascending output stream.
//  Per-channel FIFO buffering, req/ack handshakes, registered output stage.
//  Sits between sorter leaves and downstream consumers; instances cascade.
// PARAMETERS
//  DW   8  data width, unsigned
//  NCH  4  input channel count, >=2
//  L    16 per-channel FIFO depth, power of two, >=2
// PORTS
//  clk        in  1          clock, rising edge
//  rst        in  1          synchronous reset, active-high
//  data_in    in  NCH*DW     channel c at [c*DW +: DW]
//  last_in    in  NCH        final word of channel c's frame
//  req_in     in  NCH        channel c word valid
//  ack_in     out NCH        channel c can accept; = !full[c]
//  data_o     out DW         merged word
//  src_o      out clog2(NCH) channel the word came from
//  last_o     out 1          final word of merged frame
//  req_o      out 1          output valid
//  ack_o      in  1          consumer accepts
//  order_err  out NCH        sticky per-channel ordering error
// BEHAVIOUR
//  - Transfer: req&ack high on the same rising edge. Same rule on all sides.
//  - Each FIFO stores {last,data}. ack_in[c]=!full[c]. A push on a full FIFO is
//    refused even when a pop happens the same cycle.
//  - done[c] is set when a word with last=1 is popped from channel c.
//    A channel is active while !done[c]. Every frame holds >=1 word per channel.
//  - Load condition: (!req_o | ack_o) & >=1 active channel & every active
//    channel FIFO non-empty. Without it: no pop, output reg holds or empties.
//  - Winner: minimum head among active channels, unsigned compare; ties go to
//    the lowest index. Winner is popped into the output reg in the same cycle.
//  - last_o=1 only when the popped word completes the last active channel.
//  - FSM RUN -> END on a load with last_o=1. END lasts 1 cycle: clears done[],
//    no load, then RUN. Output reg may still hold that word during END.
//  - Latency: a word pushed at edge t is at its FIFO head after t. Earliest
//    req_o is after edge t+1. Throughput is 1 word/cycle in RUN.
//  - Output stable: data_o/src_o/last_o do not change while req_o&!ack_o.
//  - Reset values: req_o=0, data_o=0, src_o=0, last_o=0, order_err=0,
//    ack_in=all 1. FIFOs and done[] are cleared, FSM=RUN.
//  - Reset mid-frame: all buffered and in-flight words are discarded. The first
//    post-reset push starts a new frame.
//  - Asserted simultaneous push to and pop from the same FIFO are legal.
//    Count is unchanged.
// CONFIGURATION
//  ORDER_CHECK_EN defined: per-channel prev[c] register.
//    - A push with data < prev[c] sets order_err[c] on the next edge. It is
//      sticky until rst.
//    - prev[c] is invalidated after a pushed last word.
//    - The offending word is still merged.
//  ORDER_CHECK_EN undefined: order_err tied to 0. No prev registers.
// TESTING (NCH=4, DW=8, L=4)
//  1 Reset: rst=1 for 2 cycles -> req_o=0, ack_in=4'b1111, order_err=0.
//  2 Merge: ch0{1,5,9L} ch1{2,6L} ch2{3L} ch3{0,4,8L}, ack_o=1 ->
//    data 0,1,2,3,4,5,6,8,9; src 3,0,1,2,3,0,1,3,0; last_o only on 9.
//  3 Stall/tie: ch0{5}, ch2{5}, ch1 and ch3 empty -> req_o stays 0.
//    Then push ch1{7}, ch3{6} -> out 5(src0), 5(src2), 6, 7.
//  4 Backpressure: ack_o=0, push 5 words to ch0, others empty ->
//    ack_in[0]=0 after the 4th push. The held data_o is unchanged for 10 cycles.
//  5 Reset mid-frame: rst after the 3rd output of test 2 -> next cycle req_o=0,
//    ack_in=1111. Rerunning test 2 gives the identical sequence.
//  6 ORDER_CHECK_EN: ch2 pushes 8 then 3 -> order_err=4'b0100, held until rst.
//    Without the macro, order_err stays 0.

Source files
------------

// File: rtl/seq_merger_n_if.sv
// Stream bundle for seq_merger_n: NCH framed input streams plus the merged output.
// The slave modport is the merger's view; the master modport is the producer/consumer side.
interface seq_merger_n_if #(
  parameter int DW  = 8,
  parameter int NCH = 4
);
  localparam int SW = $clog2(NCH);

  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    last_in;
  logic [NCH-1:0]    req_in;
  logic [NCH-1:0]    ack_in;
  logic [DW-1:0]     data_o;
  logic [SW-1:0]     src_o;
  logic              last_o;
  logic              req_o;
  logic              ack_o;
  logic [NCH-1:0]    order_err;

  modport master (
    output data_in, last_in, req_in, ack_o,
    input  ack_in, data_o, src_o, last_o, req_o, order_err
  );

  modport slave (
    input  data_in, last_in, req_in, ack_o,
    output ack_in, data_o, src_o, last_o, req_o, order_err
  );
endinterface

// File: rtl/seq_merger_n.sv
// seq_merger_n: merges NCH ascending, last-framed streams into one ascending stream via
// per-channel FIFOs and a registered output stage. Define ORDER_CHECK_EN for order checks.
module seq_merger_n #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int L   = 16
) (
  input  logic          clk,
  input  logic          rst,
  seq_merger_n_if.slave bus
);
  localparam int SW = $clog2(NCH);
  localparam int AW = $clog2(L);
  localparam int EW = DW + 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(L);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_END = 1'b1
  } state_e;

  logic [EW-1:0]  mem_q  [NCH][L];
  logic [AW:0]    wptr_q [NCH];
  logic [AW:0]    rptr_q [NCH];

  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] head_last;
  logic [DW-1:0]  head_data [NCH];
  logic [DW-1:0]  in_data   [NCH];

  state_e         state_q;
  logic [NCH-1:0] done_q;
  logic           req_o_q;
  logic           last_o_q;
  logic [DW-1:0]  data_o_q;
  logic [SW-1:0]  src_o_q;

  logic [NCH-1:0] active;
  logic [NCH-1:0] win_onehot;
  logic [SW-1:0]  win_idx;
  logic [DW-1:0]  win_data;
  logic           win_found;
  logic           win_last;
  logic           take;
  logic           frame_end;
  logic           load;

  // FIFO status and head-of-queue views per channel
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      in_data[c]   = bus.data_in[c*DW +: DW];
      full[c]      = ((wptr_q[c] - rptr_q[c]) == FULL_CNT);
      empty[c]     = (wptr_q[c] == rptr_q[c]);
      push[c]      = bus.req_in[c] & ~full[c];
      head_data[c] = mem_q[c][rptr_q[c][AW-1:0]][DW-1:0];
      head_last[c] = mem_q[c][rptr_q[c][AW-1:0]][DW];
    end
  end

  // Winner selection: strict less-than keeps ties on the lowest index
  always_comb begin
    active    = ~done_q;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    take      = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      take      = active[c] & (~win_found | (head_data[c] < win_data));
      win_found = win_found | take;
      win_idx   = take ? SW'(c) : win_idx;
      win_data  = take ? head_data[c] : win_data;
    end
    win_onehot = ONE_HOT0 << win_idx;
    win_last   = head_last[win_idx];
    // The frame ends when the winner's last word leaves no other channel active
    frame_end  = win_last & ((active & ~win_onehot) == '0);
    load       = (state_q == ST_RUN) & (~req_o_q | bus.ack_o) & win_found
               & ((active & empty) == '0);
    pop        = load ? win_onehot : '0;
  end

  // FIFO storage array, write side only
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c][AW-1:0]] <= {bus.last_in[c], in_data[c]};
      end
    end
  end

  // FIFO read/write pointers with one extra wrap bit for full detection
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) begin
          wptr_q[c] <= wptr_q[c] + PTR_ONE;
        end
        if (pop[c]) begin
          rptr_q[c] <= rptr_q[c] + PTR_ONE;
        end
      end
    end
  end

  // Merge FSM with registered output stage and per-frame done tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      done_q   <= '0;
      req_o_q  <= 1'b0;
      data_o_q <= '0;
      src_o_q  <= '0;
      last_o_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load) begin
            req_o_q  <= 1'b1;
            data_o_q <= win_data;
            src_o_q  <= win_idx;
            last_o_q <= frame_end;
            done_q   <= done_q | (win_last ? win_onehot : '0);
            if (frame_end) begin
              state_q <= ST_END;
            end
          end else if (bus.ack_o) begin
            req_o_q <= 1'b0;
          end
        end
        ST_END: begin
          done_q  <= '0;
          state_q <= ST_RUN;
          if (bus.ack_o) begin
            req_o_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= '0;
          req_o_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_in = ~full;
  assign bus.data_o = data_o_q;
  assign bus.src_o  = src_o_q;
  assign bus.last_o = last_o_q;
  assign bus.req_o  = req_o_q;

`ifdef ORDER_CHECK_EN
  logic [DW-1:0]  prev_q [NCH];
  logic [NCH-1:0] prev_vld_q;
  logic [NCH-1:0] order_err_q;

  // Sticky flag when an accepted word is below its predecessor in the same frame
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_q  <= '0;
      order_err_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        prev_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) begin
          if (prev_vld_q[c] && (in_data[c] < prev_q[c])) begin
            order_err_q[c] <= 1'b1;
          end
          prev_q[c]     <= in_data[c];
          prev_vld_q[c] <= ~bus.last_in[c];
        end
      end
    end
  end

  assign bus.order_err = order_err_q;
`else
  assign bus.order_err = '0;
`endif

endmodule

// File: tb/tb_seq_merger_n.sv
// Bench for seq_merger_n (NCH=4, DW=8, L=4): directed scenarios plus randomized
// multi-frame streams compared with a queue-based sorted-merge reference model.
module tb_seq_merger_n;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int L   = 4;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seq_merger_n_if #(.DW(DW), .NCH(NCH)) bus ();

  seq_merger_n #(.DW(DW), .NCH(NCH), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW:0]    chq [NCH][$];   // {last,data}, one or more frames per channel
  logic [DW+SW:0] exp_q [$];      // {last,src,data}
  logic [DW+SW:0] got_q [$];

  task automatic idle_inputs();
    bus.req_in  = '0;
    bus.last_in = '0;
    bus.data_in = '0;
    bus.ack_o   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input int c, input int d, input bit l);
    chq[c].push_back({l, 8'(d)});
  endtask

  task automatic clear_chq();
    for (int c = 0; c < NCH; c++) chq[c].delete();
  endtask

  task automatic load_spec_lists();
    clear_chq();
    add(0, 1, 0); add(0, 5, 0); add(0, 9, 1);
    add(1, 2, 0); add(1, 6, 1);
    add(2, 3, 1);
    add(3, 0, 0); add(3, 4, 0); add(3, 8, 1);
  endtask

  task automatic gen_frames(input int nf);
    int n;
    int v;
    clear_chq();
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(1, 5);
        v = $urandom_range(0, 40);
        for (int i = 0; i < n; i++) begin
          v = v + $urandom_range(0, 50);
          if (v > 255) v = 255;
          add(c, v, (i == n - 1));
        end
      end
    end
  endtask

  // Reference: frame by frame, repeatedly take the smallest head among unfinished channels
  task automatic build_model();
    logic [DW:0]    w [NCH][$];
    logic [DW:0]    wd;
    logic [NCH-1:0] act;
    int best;
    bit any;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) w[c] = chq[c];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int c = 0; c < NCH; c++) if (w[c].size() > 0) any = 1'b1;
      if (any) begin
        act = '1;
        while (act != '0) begin
          best = -1;
          for (int c = 0; c < NCH; c++) begin
            if (act[c] && w[c].size() > 0) begin
              if (best < 0) best = c;
              else if (w[c][0][DW-1:0] < w[best][0][DW-1:0]) best = c;
            end
          end
          if (best < 0) break;
          wd = w[best].pop_front();
          if (wd[DW]) act[best] = 1'b0;
          exp_q.push_back({(wd[DW] && act == '0), SW'(best), wd[DW-1:0]});
        end
      end
    end
  endtask

  task automatic push_word(input int c, input int d, input bit l, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.req_in[c]            = 1'b1;
    bus.data_in[c*DW +: DW]  = 8'(d);
    bus.last_in[c]           = l;
    for (int k = 0; k < 40; k++) begin
      if (bus.ack_in[c]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    bus.req_in[c]  = 1'b0;
    bus.last_in[c] = 1'b0;
  endtask

  task automatic push_all(output bit ok);
    bit one;
    ok = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < chq[c].size(); i++) begin
        push_word(c, int'(chq[c][i][DW-1:0]), chq[c][i][DW], one);
        if (!one) ok = 1'b0;
      end
    end
  endtask

  task automatic collect_n(input int n, input int budget, output bit ok);
    got_q.delete();
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      bus.ack_o = 1'b1;
      if (bus.req_o) got_q.push_back({bus.last_o, bus.src_o, bus.data_o});
      if (got_q.size() == n) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.ack_o = 1'b0;
  endtask

  // Concurrent random pushes on all channels with random consumer backpressure
  task automatic run_stream(input int push_pct, input int ack_pct, input int budget,
                            output bit ok, output int stab_bad);
    int pi [NCH];
    bit prev_stall;
    logic [DW+SW:0] held;
    got_q.delete();
    stab_bad   = 0;
    prev_stall = 1'b0;
    held       = '0;
    for (int c = 0; c < NCH; c++) pi[c] = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (prev_stall && (bus.req_o !== 1'b1 || {bus.last_o, bus.src_o, bus.data_o} !== held))
        stab_bad++;
      for (int c = 0; c < NCH; c++) begin
        if (pi[c] < chq[c].size() && $urandom_range(0, 99) < push_pct) begin
          bus.req_in[c]           = 1'b1;
          bus.data_in[c*DW +: DW] = chq[c][pi[c]][DW-1:0];
          bus.last_in[c]          = chq[c][pi[c]][DW];
        end else begin
          bus.req_in[c]  = 1'b0;
          bus.last_in[c] = 1'b0;
        end
      end
      bus.ack_o = ($urandom_range(0, 99) < ack_pct);
      if (bus.req_o && bus.ack_o) got_q.push_back({bus.last_o, bus.src_o, bus.data_o});
      for (int c = 0; c < NCH; c++) if (bus.req_in[c] && bus.ack_in[c]) pi[c]++;
      prev_stall = bus.req_o && !bus.ack_o;
      held       = {bus.last_o, bus.src_o, bus.data_o};
      if (got_q.size() == exp_q.size()) break;
    end
    ok = (got_q.size() == exp_q.size());
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o: got %b want 0", bus.req_o); end
    checks++; if (bus.ack_in !== 4'b1111) begin errors++; $display("FAIL reset_ack_in: got %b want 1111", bus.ack_in); end
    checks++; if (bus.order_err !== 4'b0000) begin errors++; $display("FAIL reset_order_err: got %b want 0000", bus.order_err); end
    checks++; if (bus.data_o !== 8'd0) begin errors++; $display("FAIL reset_data_o: got %0d want 0", bus.data_o); end
    checks++; if (bus.src_o !== 2'd0) begin errors++; $display("FAIL reset_src_o: got %0d want 0", bus.src_o); end
    checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL reset_last_o: got %b want 0", bus.last_o); end
  endtask

  task automatic test_merge();
    bit okp;
    bit okc;
    do_reset();
    load_spec_lists();
    build_model();
    push_all(okp);
    collect_n(exp_q.size(), 200, okc);
    checks++; if (!(okp && okc)) begin errors++; $display("FAIL merge_done: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL merge_word[%0d]: got last=%b src=%0d data=%0d want last=%b src=%0d data=%0d", i,
                 got_q[i][DW+SW], got_q[i][DW+SW-1:DW], got_q[i][DW-1:0],
                 exp_q[i][DW+SW], exp_q[i][DW+SW-1:DW], exp_q[i][DW-1:0]);
      end
    end
  endtask

  task automatic test_stall_tie();
    bit ok;
    bit okc;
    logic [DW-1:0] ed [4];
    logic [SW-1:0] es [4];
    logic          el [4];
    ed = '{8'd5, 8'd5, 8'd6, 8'd7};
    es = '{2'd0, 2'd2, 2'd3, 2'd1};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    push_word(0, 5, 1'b1, ok);
    push_word(2, 5, 1'b1, ok);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL stall_req_o: got %b want 0", bus.req_o); end
    end
    push_word(1, 7, 1'b1, ok);
    push_word(3, 6, 1'b1, ok);
    collect_n(4, 100, okc);
    checks++; if (!okc) begin errors++; $display("FAIL tie_done: got %0d words want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {el[i], es[i], ed[i]}) begin
        errors++;
        $display("FAIL tie_word[%0d]: got last=%b src=%0d data=%0d want last=%b src=%0d data=%0d", i,
                 got_q[i][DW+SW], got_q[i][DW+SW-1:DW], got_q[i][DW-1:0], el[i], es[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit okc;
    logic [DW-1:0] ed [7];
    logic [SW-1:0] es [7];
    ed = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    push_word(0, 10, 1'b0, ok);
    push_word(0, 20, 1'b0, ok);
    push_word(0, 30, 1'b0, ok);
    checks++; if (bus.ack_in[0] !== 1'b1) begin errors++; $display("FAIL bp_ack_after3: got %b want 1", bus.ack_in[0]); end
    push_word(0, 40, 1'b1, ok);
    checks++; if (bus.ack_in[0] !== 1'b0) begin errors++; $display("FAIL bp_ack_after4: got %b want 0", bus.ack_in[0]); end
    @(negedge clk);
    bus.req_in[0]        = 1'b1;
    bus.data_in[0 +: DW] = 8'd99;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.ack_in[0] !== 1'b0 || bus.req_o !== 1'b0) begin
        errors++; $display("FAIL bp_refuse: got ack_in0=%b req_o=%b want 0 0", bus.ack_in[0], bus.req_o);
      end
      @(negedge clk);
    end
    bus.req_in[0] = 1'b0;
    push_word(1, 50, 1'b1, ok);
    push_word(2, 60, 1'b1, ok);
    push_word(3, 70, 1'b1, ok);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.req_o !== 1'b1 || bus.data_o !== 8'd10 || bus.src_o !== 2'd0) begin
        errors++; $display("FAIL bp_hold: got req=%b data=%0d src=%0d want 1 10 0", bus.req_o, bus.data_o, bus.src_o);
      end
      @(negedge clk);
    end
    checks++; if (bus.ack_in[0] !== 1'b1) begin errors++; $display("FAIL bp_ack_after_pop: got %b want 1", bus.ack_in[0]); end
    collect_n(7, 100, okc);
    checks++; if (!okc) begin errors++; $display("FAIL bp_done: got %0d words want 7", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {(i == 6), es[i], ed[i]}) begin
        errors++;
        $display("FAIL bp_word[%0d]: got last=%b src=%0d data=%0d want last=%b src=%0d data=%0d", i,
                 got_q[i][DW+SW], got_q[i][DW+SW-1:DW], got_q[i][DW-1:0], (i == 6), es[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit okp;
    bit okc;
    do_reset();
    load_spec_lists();
    build_model();
    push_all(okp);
    collect_n(3, 100, okc);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_pre[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL midrst_req_o: got %b want 0", bus.req_o); end
    checks++; if (bus.ack_in !== 4'b1111) begin errors++; $display("FAIL midrst_ack_in: got %b want 1111", bus.ack_in); end
    push_all(okp);
    collect_n(exp_q.size(), 200, okc);
    checks++; if (!(okp && okc)) begin errors++; $display("FAIL midrst_done: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_order();
    bit ok;
    logic [NCH-1:0] err_exp;
`ifdef ORDER_CHECK_EN
    err_exp = 4'b0100;
`else
    err_exp = 4'b0000;
`endif
    do_reset();
    push_word(2, 8, 1'b0, ok);
    checks++; if (bus.order_err !== 4'b0000) begin errors++; $display("FAIL order_first: got %b want 0000", bus.order_err); end
    push_word(2, 3, 1'b0, ok);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.order_err !== err_exp) begin errors++; $display("FAIL order_sticky: got %b want %b", bus.order_err, err_exp); end
      @(negedge clk);
    end
    do_reset();
    checks++; if (bus.order_err !== 4'b0000) begin errors++; $display("FAIL order_clear: got %b want 0000", bus.order_err); end
  endtask

  task automatic test_random();
    bit ok;
    int stab;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      gen_frames($urandom_range(1, 3));
      build_model();
      run_stream($urandom_range(30, 100), $urandom_range(30, 100), 3000, ok, stab);
      checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d]: got %0d words want %0d", it, got_q.size(), exp_q.size()); end
      checks++; if (stab !== 0) begin errors++; $display("FAIL rand_stable[%0d]: got %0d changes while stalled want 0", it, stab); end
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d][%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
      checks++; if (bus.order_err !== 4'b0000) begin errors++; $display("FAIL rand_order_err[%0d]: got %b want 0000", it, bus.order_err); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int stab;
    do_reset();
    gen_frames(4);
    build_model();
    run_stream(100, 100, 3000, ok, stab);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: got %0d words want %0d", got_q.size(), exp_q.size()); end
    checks++; if (stab !== 0) begin errors++; $display("FAIL b2b_stable: got %0d want 0", stab); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_merge();
    test_stall_tie();
    test_backpressure();
    test_reset_mid_frame();
    test_order();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
